// File: rtl/inst_mem_loader_if.sv
// Loader-side bundle: start/size command, byte stream handshake, memory write port and status.
// master = image source / boot controller, slave = inst_mem_loader.
interface inst_mem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              cpu_hold;
    logic              err;

    modport master (
        output start, num_words, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold, err
    );

    modport slave (
        input  start, num_words, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold, err
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Packs a little-endian byte stream into 32-bit words written to imem from addr 0; optional LOADER_CHECKSUM_EN trailer.
// Latency: mem_we one cycle after the 4th byte of a word; done/cpu_hold release the cycle after the last write.
// Backpressure: byte_ready=1 throughout RECV (and CHK), including write cycles, so 1 byte/cycle is sustained.
module inst_mem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic             clk,
    input  logic             rst,
    inst_mem_loader_if.slave lif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [1:0] S_CHK  = 2'd2;
`endif

    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W:0]   n_q,         n_d;
    logic [ADDR_W:0]   word_cnt_q,  word_cnt_d;
    logic [1:0]        byte_cnt_q,  byte_cnt_d;
    logic [23:0]       asm_q,       asm_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q,      done_d;
    logic              cpu_hold_q,  cpu_hold_d;
    logic              err_q,       err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q,      csum_d;
`endif

    logic byte_ready;
    logic xfer;
    logic start_ok;
    logic last_word;

`ifdef LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == S_RECV) || (state_q == S_CHK);
`else
    assign byte_ready = (state_q == S_RECV);
`endif

    assign xfer      = lif.byte_valid && byte_ready;
    assign start_ok  = (lif.num_words != '0) && (lif.num_words <= DEPTH_V);
    assign last_word = ((word_cnt_q + 1'b1) == n_q);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        cpu_hold_d  = cpu_hold_q;
        err_d       = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                // Release the core only once the final word's write strobe has gone out.
                if ((state_q == S_DONE) && !done_q) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
                if (lif.start) begin
                    if (start_ok) begin
                        state_d    = S_RECV;
                        n_d        = lif.num_words;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        err_d      = 1'b0;
                        done_d     = 1'b0;
                        cpu_hold_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = 8'h00;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_RECV: begin
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ lif.byte_in;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        mem_wdata_d = {lif.byte_in, asm_q};
                        word_cnt_d  = word_cnt_q + 1'b1;
                        byte_cnt_d  = 2'd0;
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    asm_d[7:0]   = lif.byte_in;
                            2'd1:    asm_d[15:8]  = lif.byte_in;
                            default: asm_d[23:16] = lif.byte_in;
                        endcase
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    if (lif.byte_in != csum_q) begin
                        state_d    = S_IDLE;
                        err_d      = 1'b1;
                        done_d     = 1'b0;
                        cpu_hold_d = 1'b1;
                    end else begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            cpu_hold_q  <= 1'b1;
            err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            cpu_hold_q  <= cpu_hold_d;
            err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign lif.byte_ready = byte_ready;
    assign lif.mem_we     = mem_we_q;
    assign lif.mem_addr   = mem_addr_q;
    assign lif.mem_wdata  = mem_wdata_q;
    assign lif.busy       = byte_ready || mem_we_q;
    assign lif.done       = done_q;
    assign lif.cpu_hold   = cpu_hold_q;
    assign lif.err        = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed + randomized bench for inst_mem_loader; expected writes come from the word list sent (word i -> addr i).
module tb_inst_mem_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0]       words [DEPTH];
    logic [ADDR_W-1:0] log_addr [$];
    logic [31:0]       log_data [$];
    logic [7:0]        last_csum;

    inst_mem_loader_if #(.ADDR_W(ADDR_W)) lif ();

    inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .lif (lif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && lif.mem_we) begin
            log_addr.push_back(lif.mem_addr);
            log_data.push_back(lif.mem_wdata);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_byte_ready"}, 32'(lif.byte_ready), 32'd0);
        chk({tag, "_mem_we"},     32'(lif.mem_we),     32'd0);
        chk({tag, "_mem_addr"},   32'(lif.mem_addr),   32'd0);
        chk({tag, "_mem_wdata"},  lif.mem_wdata,       32'd0);
        chk({tag, "_busy"},       32'(lif.busy),       32'd0);
        chk({tag, "_done"},       32'(lif.done),       32'd0);
        chk({tag, "_cpu_hold"},   32'(lif.cpu_hold),   32'd1);
        chk({tag, "_err"},        32'(lif.err),        32'd0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    // Entered and left just after a falling edge.
    task automatic start_pulse(input int n);
        lif.num_words = 7'(n);
        lif.start     = 1'b1;
        @(negedge clk);
        lif.start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit rdy_chk, input string tag);
        bit acc;
        int guard;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        if (rdy_chk) chk({tag, "_ready_held"}, 32'(lif.byte_ready), 32'd1);
        lif.byte_in    = b;
        lif.byte_valid = 1'b1;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            acc = lif.byte_ready;
            @(negedge clk);
            guard++;
        end
        lif.byte_valid = 1'b0;
        if (!acc) chk({tag, "_byte_accept_timeout"}, 32'(acc), 32'd1);
    endtask

    task automatic send_words(input int n, input bit gaps, input bit rdy_chk, input string tag);
        last_csum = 8'h00;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] wv;
                logic [7:0]  bv;
                wv = words[w];
                bv = wv[8*k +: 8];
                last_csum = last_csum ^ bv;
                send_byte(bv, gaps, rdy_chk, tag);
            end
        end
    endtask

    task automatic load(input int n, input bit gaps, input bit rdy_chk, input string tag);
        start_pulse(n);
        send_words(n, gaps, rdy_chk, tag);
`ifdef LOADER_CHECKSUM_EN
        send_byte(last_csum, gaps, rdy_chk, tag);
`endif
    endtask

    task automatic wait_done(input string tag);
        int g;
        g = 0;
        while (!lif.done && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_done"},     32'(lif.done),     32'd1);
        chk({tag, "_cpu_hold"}, 32'(lif.cpu_hold), 32'd0);
        chk({tag, "_busy"},     32'(lif.busy),     32'd0);
    endtask

    task automatic check_writes(input int n, input string tag);
        chk({tag, "_write_count"}, 32'(log_addr.size()), 32'(n));
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[i]), 32'(i));
            chk($sformatf("%s_data%0d", tag, i), log_data[i], words[i]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst            = 1'b1;
        lif.start      = 1'b0;
        lif.num_words  = '0;
        lif.byte_in    = '0;
        lif.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1: single word
        clear_log();
        words[0] = 32'h0000_2083;
        load(1, 1'b0, 1'b0, "t1");
`ifndef LOADER_CHECKSUM_EN
        chk("t1_we_cycle_mem_we",   32'(lif.mem_we),   32'd1);
        chk("t1_we_cycle_done",     32'(lif.done),     32'd0);
        chk("t1_we_cycle_cpu_hold", 32'(lif.cpu_hold), 32'd1);
        @(negedge clk);
`endif
        wait_done("t1");
        chk("t1_ready_after", 32'(lif.byte_ready), 32'd0);
        check_writes(1, "t1");

        // T2: three words back-to-back
        clear_log();
        words[0] = 32'h0000_2083;
        words[1] = 32'h0040_2103;
        words[2] = 32'h0020_81b3;
        load(3, 1'b0, 1'b1, "t2");
        wait_done("t2");
        check_writes(3, "t2");

        // T3: full depth, random data and gaps
        clear_log();
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        load(DEPTH, 1'b1, 1'b0, "t3");
        wait_done("t3");
        chk("t3_ready_after", 32'(lif.byte_ready), 32'd0);
        lif.byte_in    = 8'hEE;
        lif.byte_valid = 1'b1;
        repeat (10) @(negedge clk);
        lif.byte_valid = 1'b0;
        check_writes(DEPTH, "t3");

        // T4: illegal sizes then a legal load
        clear_log();
        start_pulse(0);
        chk("t4_zero_err",   32'(lif.err),        32'd1);
        chk("t4_zero_busy",  32'(lif.busy),       32'd0);
        chk("t4_zero_ready", 32'(lif.byte_ready), 32'd0);
        start_pulse(DEPTH + 1);
        chk("t4_over_err",   32'(lif.err),        32'd1);
        chk("t4_over_ready", 32'(lif.byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_no_write", 32'(log_addr.size()), 32'd0);
        words[0] = $urandom;
        words[1] = $urandom;
        start_pulse(2);
        chk("t4_err_cleared", 32'(lif.err),  32'd0);
        chk("t4_busy",        32'(lif.busy), 32'd1);
        send_words(2, 1'b1, 1'b0, "t4");
`ifdef LOADER_CHECKSUM_EN
        send_byte(last_csum, 1'b0, 1'b0, "t4");
`endif
        wait_done("t4");
        check_writes(2, "t4");

        // T5: reset in the middle of word 5 of 8
        clear_log();
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        start_pulse(8);
        send_words(4, 1'b1, 1'b0, "t5a");
        send_byte(words[4][7:0],  1'b0, 1'b0, "t5a");
        send_byte(words[4][15:8], 1'b0, 1'b0, "t5a");
        #1 rst = 1'b1;
        #1 chk_reset_vals("t5_midreset");
        check_writes(4, "t5_partial");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        load(8, 1'b1, 1'b0, "t5b");
        wait_done("t5b");
        check_writes(8, "t5b");

`ifdef LOADER_CHECKSUM_EN
        // T6: checksum trailer good then bad
        clear_log();
        words[0] = 32'h0000_2083;
        start_pulse(1);
        send_words(1, 1'b0, 1'b0, "t6a");
        send_byte(8'hA3, 1'b0, 1'b0, "t6a");
        wait_done("t6a");
        chk("t6a_err", 32'(lif.err), 32'd0);
        check_writes(1, "t6a");
        start_pulse(1);
        send_words(1, 1'b0, 1'b0, "t6b");
        send_byte(8'h00, 1'b0, 1'b0, "t6b");
        chk("t6b_err",      32'(lif.err),        32'd1);
        chk("t6b_done",     32'(lif.done),       32'd0);
        chk("t6b_cpu_hold", 32'(lif.cpu_hold),   32'd1);
        chk("t6b_ready",    32'(lif.byte_ready), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
